pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_gen_if.sv | 42 ++++
 rtl/pc_gen_redirect_arb.sv | 58 +++++
 rtl/pc_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-address generator: FSM states, redirect
// priority encoding and the sequential instruction step.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Ordered so that a plain magnitude compare gives redirect precedence.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    JMP  = 2'd1,
    BR   = 2'd2,
    TRAP = 2'd3
  } redir_prio_e;

  localparam int unsigned INST_STEP = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between the core control logic (master) and pc_gen (slave),
// plus a debug view of the FSM state.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  import pc_pkg::*;

  // Redirect requests are level-valid with no ready: whatever is high in a
  // cycle is consumed at the next edge (applied to PC or to the pending slot).
  logic            i_stall;
  logic            i_halt;
  logic            i_imem_busy;
  logic            i_dmem_busy;
  logic            i_trap;
  logic            i_br_taken;
  logic [XLEN-1:0] i_br_target;
  logic            i_jmp;
  logic [XLEN-1:0] i_jmp_target;
  logic [XLEN-1:0] o_imem_raddr;
  logic            o_imem_ren;
  logic [XLEN-1:0] o_nxt_pc;
  logic            o_flush_if;
  logic            o_flush_id;
  logic            o_misaligned;
  logic            o_halted;
  pc_state_e       state;

  modport master (
    output i_stall, i_halt, i_imem_busy, i_dmem_busy, i_trap,
           i_br_taken, i_br_target, i_jmp, i_jmp_target,
    input  o_imem_raddr, o_imem_ren, o_nxt_pc, o_flush_if, o_flush_id,
           o_misaligned, o_halted, state
  );

  modport slave (
    input  i_stall, i_halt, i_imem_busy, i_dmem_busy, i_trap,
           i_br_taken, i_br_target, i_jmp, i_jmp_target,
    output o_imem_raddr, o_imem_ren, o_nxt_pc, o_flush_if, o_flush_id,
           o_misaligned, o_halted, state
  );

endinterface

// File: rtl/pc_gen_redirect_arb.sv
// Combinational redirect arbiter: picks trap > branch > jump, clears bit 0,
// applies the alignment check and produces the pipeline flush requests.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] TRAP_ADDR = XLEN'(32'h0000_0100),
  parameter int              IALIGN    = 32
) (
  input  logic            trap,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  output logic            valid,
  output redir_prio_e     prio,
  output logic [XLEN-1:0] target,
  output logic            misaligned,
  output logic            flush_if,
  output logic            flush_id
);

  logic [XLEN-1:0] raw;

  always_comb begin
    prio     = NONE;
    raw      = '0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    if (trap) begin
      prio     = TRAP;
      raw      = TRAP_ADDR;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (br_taken) begin
      prio     = BR;
      raw      = br_target;
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (jmp) begin
      prio     = JMP;
      raw      = jmp_target;
      flush_if = 1'b1;
    end
    raw[0] = 1'b0;

    // A trap already lands on the vector, so only branch/jump are checked.
    misaligned = 1'b0;
    target     = raw;
    if (IALIGN == 32 && (prio == BR || prio == JMP) && raw[1]) begin
      misaligned = 1'b1;
      target     = TRAP_ADDR;
    end
  end

  assign valid = (prio != NONE);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register, RUN/WAIT/HALT control and the one-entry pending
// redirect slot used while an instruction or data miss is outstanding.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter logic [XLEN-1:0] TRAP_ADDR  = XLEN'(32'h0000_0100),
  parameter int              IALIGN     = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  pc_gen_if.slave  bus
);

  pc_state_e       state, state_next;
  logic [XLEN-1:0] pc, pc_next, seq_pc;
  logic            pend_valid, pend_valid_next;
  redir_prio_e     pend_prio, pend_prio_next;
  logic [XLEN-1:0] pend_addr, pend_addr_next;

  logic            busy;
  logic            redir_valid, redir_mis, redir_fif, redir_fid;
  redir_prio_e     redir_prio;
  logic [XLEN-1:0] redir_target;
  logic            pend_take;

  pc_redirect_arb #(
    .XLEN      (XLEN),
    .TRAP_ADDR (TRAP_ADDR),
    .IALIGN    (IALIGN)
  ) u_arb (
    .trap       (bus.i_trap),
    .br_taken   (bus.i_br_taken),
    .br_target  (bus.i_br_target),
    .jmp        (bus.i_jmp),
    .jmp_target (bus.i_jmp_target),
    .valid      (redir_valid),
    .prio       (redir_prio),
    .target     (redir_target),
    .misaligned (redir_mis),
    .flush_if   (redir_fif),
    .flush_id   (redir_fid)
  );

  assign busy      = bus.i_imem_busy | bus.i_dmem_busy;
  assign seq_pc    = pc + XLEN'(INST_STEP);
  // Equal priority replaces the slot so the most recent redirect wins.
  assign pend_take = redir_valid && (!pend_valid || redir_prio >= pend_prio);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (busy)                          state_next = WAIT;
        else if (!redir_valid && bus.i_halt) state_next = HALT;
      end
      WAIT:    if (!busy)      state_next = RUN;
      HALT:    if (bus.i_trap) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_next         = pc;
    pend_valid_next = pend_valid;
    pend_prio_next  = pend_prio;
    pend_addr_next  = pend_addr;
    if (state == WAIT || (state == RUN && busy)) begin
      if (pend_take) begin
        pend_valid_next = 1'b1;
        pend_prio_next  = redir_prio;
        pend_addr_next  = redir_target;
      end
    end
    case (state)
      RUN: begin
        if (!busy) begin
          if (redir_valid)                      pc_next = redir_target;
          else if (!bus.i_halt && !bus.i_stall) pc_next = seq_pc;
        end
      end
      WAIT: begin
        if (!busy) begin
          pc_next         = pend_valid_next ? pend_addr_next : seq_pc;
          pend_valid_next = 1'b0;
          pend_prio_next  = NONE;
        end
      end
      HALT:    if (bus.i_trap) pc_next = TRAP_ADDR;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc         <= RESET_ADDR;
      pend_valid <= 1'b0;
      pend_prio  <= NONE;
      pend_addr  <= '0;
    end else begin
      pc         <= pc_next;
      pend_valid <= pend_valid_next;
      pend_prio  <= pend_prio_next;
      pend_addr  <= pend_addr_next;
    end
  end

  always_comb begin
    bus.o_imem_ren   = (state != HALT);
    bus.o_halted     = (state == HALT);
    bus.o_flush_if   = (state != HALT) && redir_fif;
    bus.o_flush_id   = (state != HALT) && redir_fid;
    bus.o_misaligned = (state != HALT) && redir_mis;
    bus.o_nxt_pc     = (state == WAIT) ? pc : pc_next;
  end

  assign bus.o_imem_raddr = pc;
  assign bus.state        = state;

endmodule
